// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and constants for the period meter.
//   state_t      - measurement FSM states
//   TPD_*        - 2-bit time-per-division codes
//   tpd_window() - screen window (in clk cycles) for a given code; the same
//                  arithmetic the scope time-base divider uses, so both
//                  blocks agree on what a code means.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [1:0] TPD_0 = 2'b00;
    localparam logic [1:0] TPD_1 = 2'b01;
    localparam logic [1:0] TPD_2 = 2'b10;
    localparam logic [1:0] TPD_3 = 2'b11;

    // Window = 2 * (top0 << code) * samples. Only ever evaluated on
    // elaboration-time constants, so it never becomes hardware.
    function automatic logic [63:0] tpd_window(input logic [1:0] code,
                                               input int top0,
                                               input int samples);
        return 64'd2 * (64'(top0) << code) * 64'(samples);
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: measurement result bundle.
//   period, high_time - last measured period / high time in clk cycles
//   meas_valid        - one-cycle pulse when results update
//   timeout           - one-cycle pulse when a measurement is abandoned
//   auto_tpd          - recommended time_per_div code
//   out_of_range      - period longer than the code-3 window
//   busy              - meter is armed or measuring
// master: the meter (drives results). slave: time-base / display control.
interface period_meter_if #(
    parameter int CNT_W = 20
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic [1:0]       auto_tpd;
    logic             out_of_range;
    logic             busy;

    modport master (
        output period, high_time, meas_valid, timeout,
               auto_tpd, out_of_range, busy
    );

    modport slave (
        input  period, high_time, meas_valid, timeout,
               auto_tpd, out_of_range, busy
    );
endinterface

// File: rtl/period_meter_sync_edge.sv
// sync_edge: brings an asynchronous pin into the clk_in domain and flags
// its edges.
//   clk_in - system clock
//   rst    - asynchronous active-low reset (clears all flops to 0)
//   d      - asynchronous input
//   s      - synchronized level
//   rise   - one-cycle pulse on a synchronized 0->1 transition
//   fall   - one-cycle pulse on a synchronized 1->0 transition
// A pin edge shows up on rise/fall SYNC_STAGES cycles after the first
// sampling clock and is acted on at the following edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an external signal in
// clk_in cycles and recommends the smallest time_per_div code whose screen
// window holds one full period (auto-ranging).
//   clk_in - system clock
//   rst    - asynchronous active-low reset
//   en     - measurement enable; low returns the meter to IDLE
//   sig_in - asynchronous signal under test
//   m      - result bundle (period, high_time, meas_valid, timeout,
//            auto_tpd, out_of_range, busy)
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W          = 20,
    parameter int TIMEOUT        = 1000000,
    parameter int TOP0           = 1,
    parameter int SCREEN_SAMPLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sig_in,
    period_meter_if.master       m
);
    localparam logic [63:0]      WIN0  = tpd_window(TPD_0, TOP0, SCREEN_SAMPLES);
    localparam logic [63:0]      WIN1  = tpd_window(TPD_1, TOP0, SCREEN_SAMPLES);
    localparam logic [63:0]      WIN2  = tpd_window(TPD_2, TOP0, SCREEN_SAMPLES);
    localparam logic [63:0]      WIN3  = tpd_window(TPD_3, TOP0, SCREEN_SAMPLES);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic sig_s, sig_rise, sig_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (sig_in),
        .s      (sig_s),
        .rise   (sig_rise),
        .fall   (sig_fall)
    );

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] hcnt, hcnt_nx;
    logic [CNT_W-1:0] high_q, high_q_nx;
    logic             hi_done, hi_done_nx;
    logic             upd, to_hit;
    logic [1:0]       tpd_nx;
    logic             oor_nx;

    // State and counters.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hcnt    <= '0;
            high_q  <= '0;
            hi_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            hcnt    <= hcnt_nx;
            high_q  <= high_q_nx;
            hi_done <= hi_done_nx;
        end
    end

    // Next state. Priority inside MEASURE: en low, then rise, then timeout,
    // so a rise landing on the timeout cycle still yields a measurement.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hcnt_nx    = hcnt;
        high_q_nx  = high_q;
        hi_done_nx = hi_done;
        upd        = 1'b0;
        to_hit     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx     = '0;
                hcnt_nx    = '0;
                high_q_nx  = '0;
                hi_done_nx = 1'b0;
                if (en) state_nx = ARMED;
            end
            ARMED: begin
                if (!en) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    hcnt_nx    = '0;
                    high_q_nx  = '0;
                    hi_done_nx = 1'b0;
                end else if (sig_rise) begin
                    state_nx   = MEASURE;
                    cnt_nx     = ONE;
                    hcnt_nx    = ONE;
                    hi_done_nx = 1'b0;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    hcnt_nx    = '0;
                    high_q_nx  = '0;
                    hi_done_nx = 1'b0;
                end else if (sig_rise) begin
                    // Close this period and immediately open the next one.
                    upd        = 1'b1;
                    cnt_nx     = ONE;
                    hcnt_nx    = ONE;
                    hi_done_nx = 1'b0;
                end else if (cnt == TO_CNT) begin
                    to_hit     = 1'b1;
                    state_nx   = ARMED;
                    cnt_nx     = '0;
                    hcnt_nx    = '0;
                    hi_done_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + ONE;
                    // hcnt only advances while the synchronized input is
                    // still in the high phase of this period.
                    if (!hi_done && sig_s) hcnt_nx = hcnt + ONE;
                    if (sig_fall && !hi_done) begin
                        hi_done_nx = 1'b1;
                        high_q_nx  = hcnt;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Auto-range: smallest code whose window holds the period just closed.
    always_comb begin
        tpd_nx = TPD_3;
        oor_nx = 1'b0;
        if      (64'(cnt) <= WIN0) tpd_nx = TPD_0;
        else if (64'(cnt) <= WIN1) tpd_nx = TPD_1;
        else if (64'(cnt) <= WIN2) tpd_nx = TPD_2;
        else if (64'(cnt) <= WIN3) tpd_nx = TPD_3;
        else                       oor_nx = 1'b1;
    end

    // Results hold across IDLE and timeouts; they change only on a
    // completed measurement.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            m.period       <= '0;
            m.high_time    <= '0;
            m.meas_valid   <= 1'b0;
            m.timeout      <= 1'b0;
            m.auto_tpd     <= TPD_3;
            m.out_of_range <= 1'b0;
        end else begin
            m.meas_valid <= upd;
            m.timeout    <= to_hit;
            if (upd) begin
                m.period       <= cnt;
                m.high_time    <= high_q;
                m.auto_tpd     <= tpd_nx;
                m.out_of_range <= oor_nx;
            end
        end
    end

    assign m.busy = (state != IDLE);
endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;
    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 4096;
    localparam int TOP0    = 1;
    localparam int SS      = 64;
    localparam int SYNC    = 2;

    logic clk = 1'b0;
    logic rst_n, en, sig;
    always #5 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) mif ();

    period_meter #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOP0(TOP0),
        .SCREEN_SAMPLES(SS), .SYNC_STAGES(SYNC)
    ) dut (
        .clk_in (clk),
        .rst    (rst_n),
        .en     (en),
        .sig_in (sig),
        .m      (mif)
    );

    typedef struct {
        int cyc;
        int per;
        int hi;
        int tpd;
        int oor;
    } ev_t;

    ev_t mv_q[$];
    int  to_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.meas_valid) begin
                ev_t e;
                e.cyc = cyc;
                e.per = int'(mif.period);
                e.hi  = int'(mif.high_time);
                e.tpd = int'(mif.auto_tpd);
                e.oor = int'(mif.out_of_range);
                mv_q.push_back(e);
            end
            if (mif.timeout) to_q.push_back(cyc);
        end
    end

    // Reference: smallest code whose screen window holds the period.
    function automatic void ref_range(input int p, output int tpd, output int oor);
        tpd = 3;
        oor = 1;
        for (int k = 3; k >= 0; k--) begin
            if (p <= 2 * (TOP0 << k) * SS) begin
                tpd = k;
                oor = 0;
            end
        end
    endfunction

    task automatic drive_period(input int p, input int h);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            sig = (i < h);
        end
    endtask

    // Drives n periods starting with a rise. When fresh (meter ARMED), the
    // first rise only arms, giving n-1 results. Otherwise the first result
    // closes the previous waveform and is skipped.
    task automatic run_wave(input string nm, input int p, input int h,
                            input int n, input bit fresh);
        int exp_n, first, tpd, oor;
        mv_q.delete();
        repeat (n) drive_period(p, h);
        ref_range(p, tpd, oor);
        exp_n = fresh ? n - 1 : n;
        first = fresh ? 0 : 1;
        n_cmp++;
        if (mv_q.size() != exp_n) begin
            n_err++;
            $display("FAIL %s count: got %0d want %0d", nm, mv_q.size(), exp_n);
        end
        for (int i = first; i < mv_q.size(); i++) begin
            n_cmp++;
            if (mv_q[i].per !== p) begin
                n_err++;
                $display("FAIL %s period[%0d]: got %0d want %0d", nm, i, mv_q[i].per, p);
            end
            n_cmp++;
            if (mv_q[i].hi !== h) begin
                n_err++;
                $display("FAIL %s high[%0d]: got %0d want %0d", nm, i, mv_q[i].hi, h);
            end
            n_cmp++;
            if (mv_q[i].tpd !== tpd || mv_q[i].oor !== oor) begin
                n_err++;
                $display("FAIL %s range[%0d]: got tpd=%0d oor=%0d want tpd=%0d oor=%0d",
                         nm, i, mv_q[i].tpd, mv_q[i].oor, tpd, oor);
            end
            if (i > first) begin
                n_cmp++;
                if (mv_q[i].cyc - mv_q[i-1].cyc !== p) begin
                    n_err++;
                    $display("FAIL %s spacing[%0d]: got %0d want %0d",
                             nm, i, mv_q[i].cyc - mv_q[i-1].cyc, p);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        sig   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mif.period !== '0 || mif.high_time !== '0 || mif.meas_valid !== 1'b0 ||
            mif.timeout !== 1'b0 || mif.auto_tpd !== 2'b11 ||
            mif.out_of_range !== 1'b0 || mif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got per=%0d hi=%0d mv=%0b to=%0b tpd=%0d oor=%0b busy=%0b want 0 0 0 0 3 0 0",
                     mif.period, mif.high_time, mif.meas_valid, mif.timeout,
                     mif.auto_tpd, mif.out_of_range, mif.busy);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mif.busy !== 1'b1) begin
            n_err++;
            $display("FAIL armed_busy: got %0b want 1", mif.busy);
        end
    endtask

    task automatic test_square();
        run_wave("square100", 100, 50, 6, 1'b1);
    endtask

    task automatic test_ranges();
        run_wave("p300", 300, 75, 4, 1'b0);
        run_wave("p256", 256, 100, 4, 1'b0);
        run_wave("p128", 128, 64, 3, 1'b0);
        run_wave("p129", 129, 10, 3, 1'b0);
        run_wave("p2000", 2000, 1000, 3, 1'b0);
        run_wave("p1024", 1024, 512, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int p, h;
            p = $urandom_range(1500, 20);
            h = $urandom_range(p - 1, 1);
            run_wave($sformatf("rand%0d", k), p, h, 3, 1'b0);
        end
    endtask

    task automatic test_timeout();
        bit got;
        en = 1'b0;
        sig = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        mv_q.delete();
        to_q.delete();
        drive_period(200, 50);
        drive_period(200, 50);
        @(negedge clk);
        sig = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (to_q.size() > 0) got = 1'b1;
        end
        n_cmp++;
        if (!got || mv_q.size() != 1) begin
            n_err++;
            $display("FAIL timeout_seen: got to=%0d mv=%0d want 1 1", to_q.size(), mv_q.size());
        end else begin
            n_cmp++;
            if (to_q[0] - mv_q[0].cyc !== TIMEOUT) begin
                n_err++;
                $display("FAIL timeout_delay: got %0d want %0d", to_q[0] - mv_q[0].cyc, TIMEOUT);
            end
        end
        n_cmp++;
        if (mif.busy !== 1'b1 || int'(mif.period) !== 200) begin
            n_err++;
            $display("FAIL timeout_hold: got busy=%0b per=%0d want 1 200", mif.busy, mif.period);
        end
        @(negedge clk);
        n_cmp++;
        if (mif.timeout !== 1'b0 || to_q.size() != 1) begin
            n_err++;
            $display("FAIL timeout_pulse: got to=%0b n=%0d want 0 1", mif.timeout, to_q.size());
        end
        run_wave("after_to", 150, 40, 3, 1'b1);
    endtask

    task automatic test_en_drop();
        run_wave("pre_drop", 100, 50, 3, 1'b0);
        mv_q.delete();
        // The rise is acted on at the third edge after the pin change.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 3) begin
                n_cmp++;
                if (mif.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_idle: got busy=%0b want 0", mif.busy);
                end
            end
            sig = (i < 50);
            en  = (i != 2);
        end
        n_cmp++;
        if (mv_q.size() != 0) begin
            n_err++;
            $display("FAIL drop_no_valid: got %0d want 0", mv_q.size());
        end
        run_wave("post_drop", 100, 50, 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        run_wave("pre_rst", 120, 60, 2, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mif.period !== '0 || mif.high_time !== '0 || mif.meas_valid !== 1'b0 ||
            mif.auto_tpd !== 2'b11 || mif.out_of_range !== 1'b0 || mif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got per=%0d hi=%0d mv=%0b tpd=%0d oor=%0b busy=%0b want 0 0 0 3 0 0",
                     mif.period, mif.high_time, mif.meas_valid, mif.auto_tpd,
                     mif.out_of_range, mif.busy);
        end
        @(negedge clk);
        sig = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_wave("post_rst", 120, 60, 3, 1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_square();
        test_ranges();
        test_random();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures an external periodic signal in `clk_in` cycles: period and high time.
- Picks the smallest 2-bit time-per-division code whose screen window holds one full period.
- Works in the opposite direction to the scope time-base divider. That block turns a `time_per_div` code into a sample clock; this block turns an observed clock back into a `time_per_div` code for auto-ranging.
- Sits between the probe input pin and the time-base / display control logic.

Parameters:
- CNT_W, 20, width of the period and high-time counters and outputs.
- TIMEOUT, 1000000, cycles without a rising edge before measurement is abandoned (must be < 2^CNT_W).
- TOP0, 1, divider top for code 2'b00; code k uses top TOP0<<k.
- SCREEN_SAMPLES, 64, samples per screen; window for code k = 2*(TOP0<<k)*SCREEN_SAMPLES cycles.
- SYNC_STAGES, 2, flops in the input synchronizer (>=2).

Ports:
- clk_in, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, measurement enable; low forces IDLE.
- sig_in, input, 1, asynchronous signal under test.
- period, output, CNT_W, last measured period in cycles.
- high_time, output, CNT_W, last measured high time in cycles.
- meas_valid, output, 1, one-cycle pulse when period/high_time/auto_tpd update.
- timeout, output, 1, one-cycle pulse on timeout.
- auto_tpd, output, 2, recommended time_per_div code.
- out_of_range, output, 1, period exceeds the code-3 window.
- busy, output, 1, high in ARMED and MEASURE.

Behaviour:
- **Reset (rst=0, async):**
  - period=0, high_time=0, meas_valid=0, timeout=0, auto_tpd=2'b11, out_of_range=0, busy=0.
  - Synchronizer flops cleared to 0; state IDLE; counters 0.
- **Input path:**
  - sig_in passes through SYNC_STAGES flops, then one delay flop for edge detection.
  - rise = s & ~s_d; fall = ~s & s_d.
  - An edge on the pin is seen SYNC_STAGES+1 cycles later.
- **States:**
  - IDLE: if en, go to ARMED.
  - ARMED: wait for rise. On rise, go to MEASURE with cnt=1, hcnt=1, hi_done=0.
  - MEASURE: cnt increments every cycle; hcnt increments while hi_done=0.
    - On fall: hi_done=1, high_q=hcnt.
    - On rise:
      - period<=cnt; high_time<=high_q.
      - auto_tpd/out_of_range computed from cnt.
      - meas_valid=1 for one cycle.
      - cnt restarts at 1, hcnt=1, hi_done=0; stay in MEASURE (back-to-back measurements).
    - If cnt==TIMEOUT with no rise that cycle:
      - timeout=1 for one cycle; go to ARMED.
      - period/high_time/auto_tpd held.
- **Counting convention:** rises detected at cycles t0 and t1 give period=t1-t0. High time = fall cycle - rise cycle.
- **Auto-range:**
  - auto_tpd = smallest k in 0..3 with period <= 2*(TOP0<<k)*SCREEN_SAMPLES.
  - If no k qualifies: auto_tpd=3, out_of_range=1; otherwise out_of_range=0.
  - Compare against constants; no multipliers.
- **Boundary cases:**
  - en low in any state: next state IDLE and counters cleared. en overrides a same-cycle rise or timeout, so no meas_valid and no timeout pulse.
  - Outputs keep their last values while in IDLE.
  - A rise on the same cycle cnt==TIMEOUT counts as a valid measurement, not a timeout.
  - First measurement after ARMED needs two rises; no meas_valid on the first rise.
  - Reset mid-MEASURE: immediate return to reset values.

Decomposition:
- Package period_meter_pkg:
  - state enum {IDLE, ARMED, MEASURE}.
  - TPD code constants 2'b00..2'b11.
  - Function computing the window for code k from TOP0/SCREEN_SAMPLES, shared with the time-base divider.
- Sub-module sync_edge: SYNC_STAGES synchronizer plus delay flop, outputting s, rise, fall; async active-low reset.

Test Plan:
- Bench settings: TOP0=1, SCREEN_SAMPLES=64 (windows 128/256/512/1024), TIMEOUT=4096, en=1.
- Square wave, period 100, high 50 -> from the second measurement on: period=100, high_time=50, auto_tpd=0, out_of_range=0, meas_valid once per 100 cycles.
- Period 300, high 75 -> period=300, high_time=75, auto_tpd=2. Then period 256 exactly -> auto_tpd=1 (boundary inclusive).
- Period 2000 -> period=2000, auto_tpd=3, out_of_range=1. Then period 1024 -> out_of_range=0, auto_tpd=3.
- Two rises then sig_in held low -> timeout pulse exactly 4096 cycles after the last detected rise, busy stays 1 (ARMED), period unchanged. A following rise pair yields a valid measurement.
- en dropped for 1 cycle coinciding with a detected rise -> no meas_valid, state IDLE then ARMED, next measurement needs two fresh rises.
- rst asserted mid-MEASURE (asynchronously, between clock edges) -> all outputs at reset values immediately (auto_tpd=3). After release, the first meas_valid comes only after two rises.
